// File: rtl/pc_pkg.sv
// Shared definitions for the program counter and its return-address stack.
package pc_pkg;

  // One action per cycle, chosen by the priority decoder.
  typedef enum logic [2:0] {
    PC_OP_HOLD,
    PC_OP_INCR,
    PC_OP_LOAD,
    PC_OP_CALL,
    PC_OP_RET
  } pc_op_e;

  localparam int unsigned PC_ADDR_W_DEF     = 13;
  localparam int unsigned PC_STEP_DEF       = 1;
  localparam int unsigned PC_DEPTH_DEF      = 4;
  localparam int unsigned PC_RESET_ADDR_DEF = 0;

  // Strobe priority: ret > call > load > incr; nothing asserted means stall.
  function automatic pc_op_e pc_decode(input logic ret, input logic call,
                                       input logic load, input logic incr);
    pc_op_e op;
    op = PC_OP_HOLD;
    if (ret)       op = PC_OP_RET;
    else if (call) op = PC_OP_CALL;
    else if (load) op = PC_OP_LOAD;
    else if (incr) op = PC_OP_INCR;
    return op;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO. Push is ignored when full, pop is ignored when empty.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = PC_ADDR_W_DEF,
  parameter int unsigned DEPTH  = PC_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] mem_d [DEPTH];
  logic              do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == PTR_W'(DEPTH));

  // Qualify requests; a simultaneous push and pop resolves as a pop.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && !full && !pop;
  end

  // Next count and next storage contents; entry cnt_q is the free slot.
  always_comb begin
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (do_pop) begin
      cnt_d = cnt_q - PTR_W'(1);
    end else if (do_push) begin
      cnt_d = cnt_q + PTR_W'(1);
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (cnt_q == PTR_W'(i)) mem_d[i] = din;
      end
    end
  end

  // Top of stack is the entry just below the count.
  always_comb begin
    top = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (cnt_q == PTR_W'(i + 1)) top = mem_q[i];
    end
  end

  // Occupancy count; cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Entry storage; contents after reset do not matter since count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_stack.sv
// Program counter with call/return support through a hardware return stack.
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W     = PC_ADDR_W_DEF,
  parameter int unsigned       STEP       = PC_STEP_DEF,
  parameter int unsigned       DEPTH      = PC_DEPTH_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(PC_RESET_ADDR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              incr,
  input  logic              load,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] tgt_addr,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              stk_empty,
  output logic              stk_full,
  output logic              stk_ovf,
  output logic              stk_udf
);

  pc_op_e            op;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_next_seq;
  logic [ADDR_W-1:0] stk_top;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              do_push, do_pop;

  // Decode the strobes and form the sequential successor (wraps naturally).
  always_comb begin
    op          = pc_decode(ret, call, load, incr);
    pc_next_seq = pc_q + ADDR_W'(STEP);
    do_push     = (op == PC_OP_CALL);
    do_pop      = (op == PC_OP_RET);
  end

  pc_ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .din   (pc_next_seq),
    .top   (stk_top),
    .empty (stk_empty),
    .full  (stk_full)
  );

  // Next pc: a call jumps even when its push is dropped; ret on empty stalls.
  always_comb begin
    pc_d = pc_q;
    unique case (op)
      PC_OP_INCR: pc_d = pc_next_seq;
      PC_OP_LOAD: pc_d = tgt_addr;
      PC_OP_CALL: pc_d = tgt_addr;
      PC_OP_RET:  if (!stk_empty) pc_d = stk_top;
      default:    pc_d = pc_q;
    endcase
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (do_push && stk_full)  ovf_d = 1'b1;
    if (do_pop  && stk_empty) udf_d = 1'b1;
  end

  // Program counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_ADDR;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign pc_addr = pc_q;
  assign stk_ovf = ovf_q;
  assign stk_udf = udf_q;

endmodule

// File: tb/tb_pc_stack.sv
// Directed vector bench for pc_stack (STEP=1 main instance, STEP=2 for wrap).
module tb_pc_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        incr = 1'b0, load = 1'b0, call = 1'b0, ret = 1'b0, err_clr = 1'b0;
  logic [12:0] tgt_addr = '0;
  logic [12:0] pc_addr, pc_addr2;
  logic        stk_empty, stk_full, stk_ovf, stk_udf;
  logic        stk_empty2, stk_full2, stk_ovf2, stk_udf2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pc_stack #(.ADDR_W(13), .STEP(1), .DEPTH(4), .RESET_ADDR(13'h0000)) dut (
    .clk(clk), .rst(rst), .incr(incr), .load(load), .call(call), .ret(ret),
    .tgt_addr(tgt_addr), .err_clr(err_clr), .pc_addr(pc_addr),
    .stk_empty(stk_empty), .stk_full(stk_full), .stk_ovf(stk_ovf), .stk_udf(stk_udf)
  );

  pc_stack #(.ADDR_W(13), .STEP(2), .DEPTH(4), .RESET_ADDR(13'h0000)) dut2 (
    .clk(clk), .rst(rst), .incr(incr), .load(load), .call(call), .ret(ret),
    .tgt_addr(tgt_addr), .err_clr(err_clr), .pc_addr(pc_addr2),
    .stk_empty(stk_empty2), .stk_full(stk_full2), .stk_ovf(stk_ovf2), .stk_udf(stk_udf2)
  );

  typedef struct {
    logic        incr, load, call, ret, err_clr;
    logic [12:0] tgt;
    logic [12:0] pc;
    logic        empty, full, ovf, udf;
    logic        chk2;
    logic [12:0] pc2;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic i, input logic l, input logic c,
                              input logic r, input logic e, input logic [12:0] t,
                              input logic [12:0] pc, input logic em, input logic fu,
                              input logic ov, input logic ud);
    vec_t v;
    v.incr = i; v.load = l; v.call = c; v.ret = r; v.err_clr = e; v.tgt = t;
    v.pc = pc; v.empty = em; v.full = fu; v.ovf = ov; v.udf = ud;
    v.chk2 = 1'b0; v.pc2 = '0;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
  endtask

  task automatic drive(input logic i, input logic l, input logic c, input logic r,
                       input logic e, input logic [12:0] t);
    incr = i; load = l; call = c; ret = r; err_clr = e; tgt_addr = t;
  endtask

  task automatic check_state(input string nm, input int idx, input logic [12:0] pc,
                             input logic em, input logic fu, input logic ov,
                             input logic ud);
    chk({nm, ".pc"}, idx, 32'(pc_addr), 32'(pc));
    chk({nm, ".empty"}, idx, 32'(stk_empty), 32'(em));
    chk({nm, ".full"}, idx, 32'(stk_full), 32'(fu));
    chk({nm, ".ovf"}, idx, 32'(stk_ovf), 32'(ov));
    chk({nm, ".udf"}, idx, 32'(stk_udf), 32'(ud));
  endtask

  // Apply inputs just after a falling edge, sample 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //               i  l  c  r  e  tgt       pc        em fu ov ud
    vecs[0]  = mk(1, 0, 0, 0, 0, 13'h0000, 13'h0001, 1, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 13'h0000, 13'h0002, 1, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 13'h0000, 13'h0003, 1, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0, 13'h0000, 13'h0004, 1, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, 0, 0, 13'h0000, 13'h0005, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 13'h0000, 13'h0005, 1, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 13'h0000, 13'h0005, 1, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 0, 13'h1FFF, 13'h1FFF, 1, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 13'h0000, 13'h0000, 1, 0, 0, 0);
    vecs[9]  = mk(0, 1, 0, 0, 0, 13'h0010, 13'h0010, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 0, 13'h0400, 13'h0400, 0, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 0, 0, 13'h0000, 13'h0401, 0, 0, 0, 0);
    vecs[12] = mk(1, 0, 0, 0, 0, 13'h0000, 13'h0402, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 0, 13'h0000, 13'h0403, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 1, 0, 13'h0000, 13'h0011, 1, 0, 0, 0);
    vecs[15] = mk(0, 0, 1, 0, 0, 13'h0100, 13'h0100, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 1, 0, 0, 13'h0200, 13'h0200, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 1, 0, 0, 13'h0300, 13'h0300, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 1, 0, 0, 13'h0400, 13'h0400, 0, 1, 0, 0);
    vecs[19] = mk(0, 0, 1, 0, 0, 13'h0500, 13'h0500, 0, 1, 1, 0);
    vecs[20] = mk(0, 0, 0, 1, 0, 13'h0000, 13'h0301, 0, 0, 1, 0);
    vecs[21] = mk(0, 0, 0, 1, 0, 13'h0000, 13'h0201, 0, 0, 1, 0);
    vecs[22] = mk(0, 0, 0, 1, 0, 13'h0000, 13'h0101, 0, 0, 1, 0);
    vecs[23] = mk(0, 0, 0, 1, 0, 13'h0000, 13'h0012, 1, 0, 1, 0);
    vecs[24] = mk(0, 0, 0, 1, 0, 13'h0000, 13'h0012, 1, 0, 1, 1);
    vecs[25] = mk(0, 0, 0, 0, 1, 13'h0000, 13'h0012, 1, 0, 0, 0);
    vecs[26] = mk(0, 0, 1, 0, 0, 13'h0050, 13'h0050, 0, 0, 0, 0);
    vecs[27] = mk(1, 1, 1, 1, 0, 13'h0777, 13'h0013, 1, 0, 0, 0);
    vecs[28] = mk(1, 1, 1, 0, 0, 13'h0060, 13'h0060, 0, 0, 0, 0);
    vecs[29] = mk(0, 0, 0, 1, 0, 13'h0000, 13'h0014, 1, 0, 0, 0);
    vecs[30] = mk(0, 0, 0, 1, 0, 13'h0000, 13'h0014, 1, 0, 0, 1);
    vecs[31] = mk(0, 0, 0, 1, 1, 13'h0000, 13'h0014, 1, 0, 0, 1);
    vecs[32] = mk(0, 0, 0, 0, 1, 13'h0000, 13'h0014, 1, 0, 0, 0);
    // STEP=2 instance: 2,4,6,8,A, hold, hold, 1FFF, wraps to 0001.
    vecs[0].chk2 = 1; vecs[0].pc2 = 13'h0002;
    vecs[4].chk2 = 1; vecs[4].pc2 = 13'h000A;
    vecs[6].chk2 = 1; vecs[6].pc2 = 13'h000A;
    vecs[7].chk2 = 1; vecs[7].pc2 = 13'h1FFF;
    vecs[8].chk2 = 1; vecs[8].pc2 = 13'h0001;

    // Reset state, then two advances, then an asynchronous reset mid-cycle.
    repeat (2) @(negedge clk);
    #1;
    check_state("reset", 0, 13'h0000, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 13'h0000);
    cycle();
    cycle();
    check_state("pre_rst", 0, 13'h0002, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 13'h0000);
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 0, 13'h0000, 1, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Main vector table.
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].incr, vecs[k].load, vecs[k].call, vecs[k].ret,
            vecs[k].err_clr, vecs[k].tgt);
      cycle();
      check_state("vec", k, vecs[k].pc, vecs[k].empty, vecs[k].full,
                  vecs[k].ovf, vecs[k].udf);
      if (vecs[k].chk2) chk("vec.pc2", k, 32'(pc_addr2), 32'(vecs[k].pc2));
      @(negedge clk);
    end

    // Overflow set wins over a same-cycle clear: fill, then call+err_clr while full.
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 0, 0, 13'h0100);
      cycle();
      @(negedge clk);
    end
    chk("fill.full", 0, 32'(stk_full), 32'd1);
    drive(0, 0, 1, 0, 1, 13'h0222);
    cycle();
    check_state("ovf_setwins", 0, 13'h0222, 0, 1, 1, 0);
    @(negedge clk);

    // Reset mid-nesting, then ret on the first edge after release underflows.
    rst = 1'b1;
    #1;
    check_state("rst_nest", 0, 13'h0000, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 13'h0100);
    rst = 1'b0;
    cycle();
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 13'h0200);
    cycle();
    check_state("nest2", 0, 13'h0200, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_state("rst_mid", 0, 13'h0000, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 13'h0000);
    rst = 1'b0;
    cycle();
    check_state("ret_after_rst", 0, 13'h0000, 1, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 13'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
